// File: rtl/zbuf_fetch.sv
// Z-buffer fetch: issues depth reads and pairs each pixel with its stored Z after RD_LAT cycles; also runs full-buffer clears.
// Latency RD_LAT cycles accept-to-output; in_ready drops on same-address hazards, while clearing, and in the clear_start cycle.
module zbuf_fetch #(
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 2,
    parameter int FB_WORDS = 307200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [26:0]       in_z,
    input  logic [15:0]       in_color,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] zrd_addr,
    input  logic [26:0]       zrd_data,
    output logic [26:0]       out_pixelZ,
    output logic [26:0]       out_currZ,
    output logic [15:0]       out_color,
    output logic              out_rasterPixel,
    output logic              out_clearPixel,
    output logic [ADDR_W-1:0] out_addr
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam int                LAST      = RD_LAT - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] addr_q [RD_LAT];
    logic [26:0]       z_q    [RD_LAT];
    logic [15:0]       col_q  [RD_LAT];

    logic hazard;
    logic accept;

    // A pending entry has not yet been written back, so reading its address now would return stale Z.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (vld_q[i] && (addr_q[i] == in_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready = (state_q == S_RUN) & ~clear_start & ~hazard;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (clear_start) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (vld_q == '0) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_q[0] <= accept;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload needs no reset: it is only observed through the valid bits.
    always_ff @(posedge clk) begin
        addr_q[0] <= in_addr;
        z_q[0]    <= in_z;
        col_q[0]  <= in_color;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_q[i] <= addr_q[i-1];
            z_q[i]    <= z_q[i-1];
            col_q[i]  <= col_q[i-1];
        end
    end

    assign zrd_addr        = (state_q == S_RUN) ? in_addr : '0;
    assign clear_busy      = (state_q != S_RUN);
    assign out_rasterPixel = vld_q[LAST];
    assign out_clearPixel  = (state_q == S_CLEAR);
    assign out_pixelZ      = out_rasterPixel ? z_q[LAST]   : '0;
    assign out_currZ       = out_rasterPixel ? zrd_data    : '0;
    assign out_color       = out_rasterPixel ? col_q[LAST] : '0;
    assign out_addr        = out_rasterPixel ? addr_q[LAST] :
                             out_clearPixel  ? cnt_q        : '0;

endmodule

// File: tb/tb_zbuf_fetch.sv
// Directed bench for zbuf_fetch with a small Z memory model (2-cycle read, write-back of raster/clear outputs).
module tb_zbuf_fetch;

    localparam int ADDR_W   = 19;
    localparam int RD_LAT   = 2;
    localparam int FB_WORDS = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [26:0]       in_z;
    logic [15:0]       in_color;
    logic              clear_start;
    logic              clear_busy;
    logic [ADDR_W-1:0] zrd_addr;
    logic [26:0]       zrd_data;
    logic [26:0]       out_pixelZ;
    logic [26:0]       out_currZ;
    logic [15:0]       out_color;
    logic              out_rasterPixel;
    logic              out_clearPixel;
    logic [ADDR_W-1:0] out_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    zbuf_fetch #(
        .ADDR_W  (ADDR_W),
        .RD_LAT  (RD_LAT),
        .FB_WORDS(FB_WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_z           (in_z),
        .in_color       (in_color),
        .clear_start    (clear_start),
        .clear_busy     (clear_busy),
        .zrd_addr       (zrd_addr),
        .zrd_data       (zrd_data),
        .out_pixelZ     (out_pixelZ),
        .out_currZ      (out_currZ),
        .out_color      (out_color),
        .out_rasterPixel(out_rasterPixel),
        .out_clearPixel (out_clearPixel),
        .out_addr       (out_addr)
    );

    // Z memory model: writes whatever the z-test stage would commit, reads with a 2-cycle latency.
    logic [26:0] mem [64];
    logic [26:0] rd_p1, rd_p2;
    assign zrd_data = rd_p2;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[16] <= 27'h1000000;
        end else if (out_rasterPixel) begin
            mem[out_addr[5:0]] <= out_pixelZ;
        end else if (out_clearPixel) begin
            mem[out_addr[5:0]] <= '0;
        end
        rd_p1 <= mem[zrd_addr[5:0]];
        rd_p2 <= rd_p1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [26:0] z, input logic [15:0] c);
        in_valid = v;
        in_addr  = a;
        in_z     = z;
        in_color = c;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_raster"}, 32'(out_rasterPixel), 32'd0);
        check({tag, "_clear"},  32'(out_clearPixel),  32'd0);
        check({tag, "_pz"},     32'(out_pixelZ),      32'd0);
        check({tag, "_cz"},     32'(out_currZ),       32'd0);
        check({tag, "_col"},    32'(out_color),       32'd0);
        check({tag, "_addr"},   32'(out_addr),        32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        clear_start = 1'b0;
        drive(1'b0, '0, '0, '0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check_idle("rst");
        check("rst_busy",  32'(clear_busy), 32'd0);
        check("rst_ready", 32'(in_ready),   32'd1);

        // Single pixel, output two cycles after acceptance
        cyc();
        drive(1'b1, 19'h00010, 27'h2000000, 16'hF800);
        #1;
        check("p1_ready", 32'(in_ready), 32'd1);
        check("p1_zrd",   32'(zrd_addr), 32'h10);
        cyc();
        drive(1'b0, '0, '0, '0);
        #1;
        check("p1_t1_raster", 32'(out_rasterPixel), 32'd0);
        cyc();
        check("p1_raster", 32'(out_rasterPixel), 32'd1);
        check("p1_pz",     32'(out_pixelZ),      32'h2000000);
        check("p1_cz",     32'(out_currZ),       32'h1000000);
        check("p1_col",    32'(out_color),       32'hF800);
        check("p1_addr",   32'(out_addr),        32'h10);
        check("p1_clr",    32'(out_clearPixel),  32'd0);
        cyc();
        check_idle("p1_after");

        // Back-to-back pixels 5,6,7 with no bubbles
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1'b1, ADDR_W'(5 + k), 27'(32'h100 + 32'(5 + k)), 16'(5 + k));
            else       drive(1'b0, '0, '0, '0);
            #1;
            if (k < 3) check("b2b_ready", 32'(in_ready), 32'd1);
            if (k >= 2) begin
                check("b2b_raster", 32'(out_rasterPixel), 32'd1);
                check("b2b_addr",   32'(out_addr),        32'(5 + k - 2));
                check("b2b_pz",     32'(out_pixelZ),      32'h100 + 32'(5 + k - 2));
                check("b2b_col",    32'(out_color),       32'(5 + k - 2));
            end
            cyc();
        end
        check("b2b_end", 32'(out_rasterPixel), 32'd0);

        // Read-after-write hazard on address 9
        drive(1'b1, 19'd9, 27'h3000000, 16'h00AA);
        #1;
        check("hz_first_ready", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b1, 19'd9, 27'h0400000, 16'h1234);
        #1;
        check("hz_ready0_a", 32'(in_ready), 32'd0);
        cyc();
        check("hz_ready0_b", 32'(in_ready),        32'd0);
        check("hz_first_out", 32'(out_rasterPixel), 32'd1);
        check("hz_first_pz", 32'(out_pixelZ),      32'h3000000);
        cyc();
        check("hz_ready1", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b0, '0, '0, '0);
        #1;
        check("hz_gap", 32'(out_rasterPixel), 32'd0);
        cyc();
        check("hz_second_out",  32'(out_rasterPixel), 32'd1);
        check("hz_second_addr", 32'(out_addr),        32'd9);
        check("hz_second_pz",   32'(out_pixelZ),      32'h0400000);
        check("hz_second_cz",   32'(out_currZ),       32'h3000000);
        check("hz_second_col",  32'(out_color),       32'h1234);
        cyc();

        // Clear with two pixels in flight; clear_start during CLEAR is ignored
        drive(1'b1, 19'd20, 27'h20, 16'h20);
        cyc();
        drive(1'b1, 19'd21, 27'h21, 16'h21);
        cyc();
        drive(1'b1, 19'd22, 27'h22, 16'h22);
        clear_start = 1'b1;
        #1;
        check("cs_ready",  32'(in_ready),        32'd0);
        check("cs_busy",   32'(clear_busy),      32'd0);
        check("cs_out20",  32'(out_addr),        32'd20);
        cyc();
        clear_start = 1'b0;
        drive(1'b0, '0, '0, '0);
        #1;
        check("dr_busy",   32'(clear_busy),      32'd1);
        check("dr_out21",  32'(out_addr),        32'd21);
        check("dr_raster", 32'(out_rasterPixel), 32'd1);
        check("dr_zrd",    32'(zrd_addr),        32'd0);
        cyc();
        check("dr_busy2",  32'(clear_busy),      32'd1);
        check("dr_empty",  32'(out_rasterPixel), 32'd0);
        check("dr_noclr",  32'(out_clearPixel),  32'd0);
        cyc();
        for (int k = 0; k < FB_WORDS; k++) begin
            clear_start = (k == 3);
            #1;
            check("clr_flag",   32'(out_clearPixel),  32'd1);
            check("clr_addr",   32'(out_addr),        32'(k));
            check("clr_raster", 32'(out_rasterPixel), 32'd0);
            check("clr_pz",     32'(out_pixelZ),      32'd0);
            check("clr_col",    32'(out_color),       32'd0);
            check("clr_busy",   32'(clear_busy),      32'd1);
            check("clr_ready",  32'(in_ready),        32'd0);
            cyc();
        end
        clear_start = 1'b0;
        #1;
        check("clr_done_busy",  32'(clear_busy),     32'd0);
        check("clr_done_flag",  32'(out_clearPixel), 32'd0);
        check("clr_done_ready", 32'(in_ready),       32'd1);
        cyc();

        // Reset during clear at address 3, then a fresh clear starts at 0
        clear_start = 1'b1;
        cyc();
        clear_start = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) cyc();
        check("rc_addr3", 32'(out_addr),       32'd3);
        check("rc_flag3", 32'(out_clearPixel), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check_idle("rc_after");
        check("rc_busy",  32'(clear_busy), 32'd0);
        check("rc_ready", 32'(in_ready),   32'd1);
        clear_start = 1'b1;
        cyc();
        clear_start = 1'b0;
        cyc();
        check("rc_restart_flag", 32'(out_clearPixel), 32'd1);
        check("rc_restart_addr", 32'(out_addr),       32'd0);
        for (int k = 0; k < FB_WORDS; k++) cyc();
        check("rc_final_busy", 32'(clear_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zbuf_fetch.md
ZBUF_FETCH -- requirements
Module: zbuf_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, Z-buffer word address width.
REQ-002 SHALL have parameter RD_LAT, default 2, Z-buffer read latency in cycles (1..4).
REQ-003 SHALL have parameter FB_WORDS, default 307200, number of Z-buffer words cleared.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream pixel present.
- in_ready  out  1  pixel accepted this cycle when in_valid & in_ready.
- in_addr  in  ADDR_W  pixel Z-buffer address.
- in_z  in  27  pixel depth, float format.
- in_color  in  16  pixel colour.
- clear_start  in  1  request full Z/colour clear.
- clear_busy  out  1  drain or clear in progress.
- zrd_addr  out  ADDR_W  Z-buffer read address.
- zrd_data  in  27  read data, valid RD_LAT cycles after zrd_addr.
- out_pixelZ  out  27  depth to z-test stage.
- out_currZ  out  27  stored depth to z-test stage.
- out_color  out  16  colour to z-test stage.
- out_rasterPixel  out  1  raster pixel present this cycle.
- out_clearPixel  out  1  clear write this cycle.
- out_addr  out  ADDR_W  write address for the z-test stage's wren.

Function
REQ-005 SHALL implement states RUN, DRAIN, CLEAR; clear_busy = 1 in DRAIN and CLEAR.
REQ-006 In RUN, zrd_addr SHALL equal in_addr combinationally; in CLEAR and DRAIN, zrd_addr SHALL be 0.
REQ-007 An accepted pixel SHALL enter an RD_LAT-deep shift pipeline carrying addr, z, color and valid.
REQ-008 Accept at cycle t SHALL produce out_rasterPixel=1 at exactly t+RD_LAT, with out_currZ=zrd_data, and out_pixelZ/out_color/out_addr equal to the accepted values.
REQ-009 The pipeline SHALL never stall internally; the downstream stage always consumes, one output per cycle maximum.
REQ-010 Hazard: in_ready SHALL be 0 when in_addr equals the address of any valid pipeline entry (a read must not overtake an unwritten pending write to the same address).
REQ-011 in_ready SHALL equal (state==RUN) & ~clear_start & ~hazard; in_ready may depend combinationally on in_addr.
REQ-012 In RUN, clear_start=1 SHALL move to DRAIN next cycle; no pixel is accepted in the clear_start cycle.
REQ-013 DRAIN SHALL hold until all pipeline valids are 0, then enter CLEAR next cycle with the counter at 0.
REQ-014 In CLEAR, each cycle SHALL output out_clearPixel=1, out_addr=counter, out_rasterPixel=0, out_color=0, out_pixelZ=0; the counter then increments.
REQ-015 When the counter reaches FB_WORDS-1, that cycle SHALL be the last clear write; the next cycle is RUN with counter 0 and clear_busy=0.
REQ-016 clear_start in DRAIN or CLEAR SHALL be ignored (no restart, no queuing).
REQ-017 out_rasterPixel and out_clearPixel SHALL never both be 1.
REQ-018 When neither flag is set, out_pixelZ, out_currZ, out_color and out_addr SHALL be 0.

Reset
REQ-019 reset=1 SHALL, on the next edge, set state RUN, counter 0 and all pipeline valids 0, and discard in-flight pixels without output.
REQ-020 After reset, all outputs SHALL be 0 except in_ready (follows REQ-011); reset mid-CLEAR SHALL abort the clear.

Verification
REQ-021 Bench SHALL cover:
- Single pixel addr=0x00010, z=0x2000000, color=0xF800, zrd_data=0x1000000 -> 2 cycles later rasterPixel=1, pixelZ=0x2000000, currZ=0x1000000, out_addr=0x00010.
- Back-to-back pixels at addrs 5, 6, 7 -> in_ready held 1, three consecutive outputs in order, no bubbles.
- Pixel at addr 9, then addr 9 next cycle -> in_ready=0 for 2 cycles; second pixel accepted once the first has written; its currZ shows the first pixel's written Z.
- clear_start with 2 pixels in flight -> both emerge, then FB_WORDS=8 (override) clear writes at addrs 0..7, clear_busy=1 throughout, then RUN.
- clear_start during CLEAR -> ignored; clear still ends after address FB_WORDS-1.
- reset asserted at clear address 3 -> next cycle all outputs 0, state RUN, next clear restarts at address 0.
